// File: rtl/piso_shift_serializer.sv
// rtl/piso_shift_serializer.sv - parallel-in serial-out shifter with a valid/ready serial port
// Define PARITY_BIT_EN to append a trailing even-parity bit to every frame.
`timescale 1ns/1ps

module piso_shift_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] par_in,
   input  logic             par_valid,
   output logic             par_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   input  logic             ser_ready,
   output logic             busy
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PARITY_BIT_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_e;
   logic parity_q, parity_d;
`else
   typedef enum logic {S_IDLE, S_SHIFT} state_e;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last_data;
   logic             data_bit;

   assign last_data = (cnt_q == LAST_IDX);
   assign data_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
`ifdef PARITY_BIT_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
`ifdef PARITY_BIT_EN
         parity_q <= parity_d;
`endif
      end
   end

   // The counter only advances on an accepted bit, so a stalled consumer never loses or repeats data.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
`ifdef PARITY_BIT_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (par_valid) begin
               shreg_d  = par_in;
               cnt_d    = '0;
               state_d  = S_SHIFT;
`ifdef PARITY_BIT_EN
               parity_d = ^par_in;
`endif
            end
         end
         S_SHIFT: begin
            if (ser_ready) begin
               shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
               cnt_d   = cnt_q + CW'(1);
               if (last_data) begin
`ifdef PARITY_BIT_EN
                  state_d = S_PARITY;
`else
                  state_d = S_IDLE;
`endif
               end
            end
         end
`ifdef PARITY_BIT_EN
         S_PARITY: begin
            if (ser_ready) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   assign par_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign ser_valid = (state_q != S_IDLE);

   always_comb begin
      ser_out  = 1'b0;
      ser_last = 1'b0;
      case (state_q)
         S_SHIFT: begin
            ser_out = data_bit;
`ifndef PARITY_BIT_EN
            ser_last = last_data;
`endif
         end
`ifdef PARITY_BIT_EN
         S_PARITY: begin
            ser_out  = parity_q;
            ser_last = 1'b1;
         end
`endif
         default: begin
            ser_out  = 1'b0;
            ser_last = 1'b0;
         end
      endcase
   end

endmodule
